// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MIPS multiply/divide unit controller:
// op encodings, default latencies and the busy counter width.
package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;
    localparam logic [2:0] MDU_RSVD  = 3'd7;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic {
        StIdle,
        StRun
    } mdu_state_e;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU connection: command/operands/flush in, busy and HI/LO out.
interface mdu_ctrl_if;

    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op,
        output rs_data,
        output rt_data,
        output flush,
        input  busy,
        input  hi,
        input  lo
    );

    modport slave (
        input  op,
        input  rs_data,
        input  rt_data,
        input  flush,
        output busy,
        output hi,
        output lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: computes the pending {hi, lo} result for
// mult/multu/div/divu and flags a zero divisor.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [31:0] o_hi_p,
    output logic [31:0] o_lo_p,
    output logic        o_div_by_zero
);

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_rt_zero;
    logic [31:0]        w_rt_nz;
    logic [31:0]        w_rs_mag;
    logic [31:0]        w_rt_mag;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;

    assign w_prod_s = $signed({{32{i_rs_data[31]}}, i_rs_data}) *
                      $signed({{32{i_rt_data[31]}}, i_rt_data});
    assign w_prod_u = {32'd0, i_rs_data} * {32'd0, i_rt_data};

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    assign w_rt_zero = (i_rt_data == 32'd0);
    assign w_rt_nz   = w_rt_zero ? 32'd1 : i_rt_data;
    assign w_rs_mag  = i_rs_data[31] ? (~i_rs_data + 32'd1) : i_rs_data;
    assign w_rt_mag  = w_rt_nz[31] ? (~w_rt_nz + 32'd1) : w_rt_nz;
    assign w_q_mag   = w_rs_mag / w_rt_mag;
    assign w_r_mag   = w_rs_mag % w_rt_mag;
    assign w_uq      = i_rs_data / w_rt_nz;
    assign w_ur      = i_rs_data % w_rt_nz;

    always_comb begin
        o_hi_p        = 32'd0;
        o_lo_p        = 32'd0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_hi_p = w_prod_s[63:32];
                o_lo_p = w_prod_s[31:0];
            end
            MDU_MULTU: begin
                o_hi_p = w_prod_u[63:32];
                o_lo_p = w_prod_u[31:0];
            end
            MDU_DIV: begin
                o_lo_p        = (i_rs_data[31] ^ i_rt_data[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
                o_hi_p        = i_rs_data[31] ? (~w_r_mag + 32'd1) : w_r_mag;
                o_div_by_zero = w_rt_zero;
            end
            MDU_DIVU: begin
                o_lo_p        = w_uq;
                o_hi_p        = w_ur;
                o_div_by_zero = w_rt_zero;
            end
            default: begin
                o_hi_p        = 32'd0;
                o_lo_p        = 32'd0;
                o_div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO, models multi-cycle mult/div latency with a
// down-counter and drives the registered busy flag for the ID-stage stall logic.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave mdu
);

    localparam logic [CNT_W-1:0] LP_MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LP_DIV_LAT  = CNT_W'(DIV_CYCLES);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_p;
    logic [31:0]      r_lo_p;
    logic             r_dbz;

    logic [31:0]      w_hi_p;
    logic [31:0]      w_lo_p;
    logic             w_dbz;
    logic             w_is_mul;

    mdu_arith u_arith (
        .i_op          (mdu.op),
        .i_rs_data     (mdu.rs_data),
        .i_rt_data     (mdu.rt_data),
        .o_hi_p        (w_hi_p),
        .o_lo_p        (w_lo_p),
        .o_div_by_zero (w_dbz)
    );

    assign w_is_mul = (mdu.op == MDU_MULT) || (mdu.op == MDU_MULTU);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_p  <= 32'd0;
            r_lo_p  <= 32'd0;
            r_dbz   <= 1'b0;
        end else if (mdu.flush) begin
            // Abandon any in-flight result; HI/LO keep their architectural values.
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi_p  <= 32'd0;
            r_lo_p  <= 32'd0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (is_arith_op(mdu.op)) begin
                        r_hi_p  <= w_hi_p;
                        r_lo_p  <= w_lo_p;
                        r_dbz   <= w_dbz;
                        r_cnt   <= w_is_mul ? LP_MULT_LAT : LP_DIV_LAT;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else if (mdu.op == MDU_MTHI) begin
                        r_hi <= mdu.rs_data;
                    end else if (mdu.op == MDU_MTLO) begin
                        r_lo <= mdu.rs_data;
                    end
                end
                StRun: begin
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_dbz) begin
                            r_hi <= r_hi_p;
                            r_lo <= r_lo_p;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.busy = r_busy;
    assign mdu.hi   = r_hi;
    assign mdu.lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_ctrl_if dut_if ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // The stall logic never issues an op while busy; flag it if the bench ever does.
    always @(posedge clk) begin
        if (reset && !dut_if.flush && dut_if.busy && dut_if.op != MDU_NONE) begin
            n_err++;
            $error("FAIL op_while_busy: observed op=%0d while busy, required op=0", dut_if.op);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one completed op, written straight from the ISA rules.
    task automatic model_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] p;
        int          q;
        int          r;
        case (op)
            MDU_MULT: begin
                p = longint'(int'(rs)) * longint'(int'(rt));
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = 64'(rs) * 64'(rt);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            MDU_DIV: begin
                if (rt == 32'd0) begin
                end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000;
                    exp_hi = 32'd0;
                end else begin
                    q = int'(rs) / int'(rt);
                    r = int'(rs) % int'(rt);
                    exp_lo = q;
                    exp_hi = r;
                end
            end
            MDU_DIVU: begin
                if (rt != 32'd0) begin
                    exp_lo = rs / rt;
                    exp_hi = rs % rt;
                end
            end
            MDU_MTHI: exp_hi = rs;
            MDU_MTLO: exp_lo = rs;
            default: begin
            end
        endcase
    endtask

    // Issue one op and check busy for every latency cycle, then the new HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] rs, input logic [31:0] rt);
        int          lat;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        lat    = (op == MDU_MULT || op == MDU_MULTU) ? 5 :
                 (op == MDU_DIV || op == MDU_DIVU) ? 10 : 0;
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        dut_if.op      = op;
        dut_if.rs_data = rs;
        dut_if.rt_data = rt;
        @(negedge clk);
        dut_if.op      = MDU_NONE;
        dut_if.rs_data = $urandom;
        dut_if.rt_data = $urandom;
        model_op(op, rs, rt);
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            check($sformatf("%s busy_c%0d", tag, i), {31'd0, dut_if.busy}, 32'd1);
            if (i == 1 || i == lat) begin
                check($sformatf("%s hi_hold_c%0d", tag, i), dut_if.hi, old_hi);
                check($sformatf("%s lo_hold_c%0d", tag, i), dut_if.lo, old_lo);
            end
        end
        if (lat > 0) @(negedge clk);
        check($sformatf("%s busy_done", tag), {31'd0, dut_if.busy}, 32'd0);
        check($sformatf("%s hi", tag), dut_if.hi, exp_hi);
        check($sformatf("%s lo", tag), dut_if.lo, exp_lo);
    endtask

    initial begin
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [2:0]  rop;
        logic [31:0] rrs;
        logic [31:0] rrt;
        int          sel;

        n_cmp          = 0;
        n_err          = 0;
        exp_hi         = 32'd0;
        exp_lo         = 32'd0;
        reset          = 1'b0;
        dut_if.op      = MDU_NONE;
        dut_if.rs_data = 32'd0;
        dut_if.rt_data = 32'd0;
        dut_if.flush   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, dut_if.busy}, 32'd0);
        check("reset hi", dut_if.hi, 32'd0);
        check("reset lo", dut_if.lo, 32'd0);
        reset = 1'b1;

        run_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu", MDU_DIVU, 32'd7, 32'd2);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mtlo_pre", MDU_MTLO, 32'h0000_5678, 32'd0);
        run_op("mthi_pre", MDU_MTHI, 32'h0000_1234, 32'd0);
        run_op("divu_zero", MDU_DIVU, 32'd99, 32'd0);
        run_op("div_zero", MDU_DIV, 32'hFFFF_0000, 32'd0);
        run_op("mthi", MDU_MTHI, 32'hAAAA_5555, 32'd0);
        @(negedge clk);
        check("mthi busy_stays_low", {31'd0, dut_if.busy}, 32'd0);

        // Flush in the third busy cycle of a mult.
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        dut_if.op      = MDU_MULT;
        dut_if.rs_data = 32'h0001_0000;
        dut_if.rt_data = 32'h0001_0000;
        @(negedge clk);
        dut_if.op = MDU_NONE;
        check("flush busy_c1", {31'd0, dut_if.busy}, 32'd1);
        @(negedge clk);
        check("flush busy_c2", {31'd0, dut_if.busy}, 32'd1);
        @(negedge clk);
        check("flush busy_c3", {31'd0, dut_if.busy}, 32'd1);
        dut_if.flush = 1'b1;
        @(negedge clk);
        dut_if.flush = 1'b0;
        check("flush busy_drop", {31'd0, dut_if.busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("flush busy_later", {31'd0, dut_if.busy}, 32'd0);
        check("flush hi", dut_if.hi, old_hi);
        check("flush lo", dut_if.lo, old_lo);

        // Flush wins over a simultaneous op.
        @(negedge clk);
        dut_if.op      = MDU_MTHI;
        dut_if.rs_data = 32'hDEAD_BEEF;
        dut_if.flush   = 1'b1;
        @(negedge clk);
        dut_if.op    = MDU_NONE;
        dut_if.flush = 1'b0;
        check("flush_vs_op hi", dut_if.hi, old_hi);
        check("flush_vs_op busy", {31'd0, dut_if.busy}, 32'd0);

        // Reset in the middle of a div.
        @(negedge clk);
        dut_if.op      = MDU_DIV;
        dut_if.rs_data = 32'd100;
        dut_if.rt_data = 32'd7;
        @(negedge clk);
        dut_if.op = MDU_NONE;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("midreset busy", {31'd0, dut_if.busy}, 32'd0);
        check("midreset hi", dut_if.hi, 32'd0);
        check("midreset lo", dut_if.lo, 32'd0);
        repeat (12) @(negedge clk);
        check("midreset hi_later", dut_if.hi, 32'd0);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(1, 6));
            rrs = $urandom;
            rrt = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rrt = 32'd0;
            if (sel == 1) begin
                rrs = 32'h8000_0000;
                rrt = 32'hFFFF_FFFF;
            end
            if (sel == 2) rrt = 32'($urandom_range(1, 9));
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, rrs, rrt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
